instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to instruction memory and
// queues returned {pc, instr} pairs in a small prefetch FIFO for the decode stage.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem    [BUF_DEPTH];
  logic [31:0]      instr_mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             outstanding;
  logic             discard;
  logic             acc_p1;
  logic [31:0]      req_pc_p1;

  logic             pop;
  logic             buf_pop;
  logic             accept;
  logic             rsp;
  logic             push;
  logic [OCC_W-1:0] occ;
  logic [31:0]      redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Head of the FIFO drives the consumer directly; nothing bypasses the buffer.
  assign if_valid  = !reset && (count != '0);
  assign if_instr  = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc     = if_valid ? pc_mem[rd_ptr]    : '0;
  assign pop       = if_valid && id_ready;
  assign imem_addr = fetch_pc;

  always_comb begin
    occ      = OCC_W'(count) + OCC_W'(outstanding) - OCC_W'(pop);
    imem_req = !reset && !redirect_valid && (occ < OCC_W'(BUF_DEPTH));
    accept   = imem_req && imem_ready;
    rsp      = imem_rvalid && outstanding;
    push     = rsp && !discard && !redirect_valid;
    buf_pop  = pop && !redirect_valid;
  end

  // Control state: fetch pointer, FIFO pointers/occupancy, in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      acc_p1      <= 1'b0;
    end else begin
      acc_p1 <= accept;
      if (accept)
        outstanding <= 1'b1;
      else if (imem_rvalid)
        outstanding <= 1'b0;

      if (redirect_valid) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= redirect_tgt;
        // A response arriving in the redirect cycle is already dropped there;
        // only a still-pending one from last cycle's request must be discarded.
        discard  <= acc_p1 && !imem_rvalid;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        if (rsp && discard)
          discard <= 1'b0;
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (buf_pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(buf_pop);
      end
    end
  end

  // Datapath: request pc capture and FIFO storage, not reset.
  always_ff @(posedge clk) begin
    if (accept)
      req_pc_p1 <= fetch_pc;
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc_p1;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the fetch unit.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model state
  logic [31:0] m_fetch_pc;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  bit          m_infl;
  bit          m_infl_drop;
  logic [31:0] m_infl_pc;
  bit          m_acc_prev;
  logic [31:0] m_acc_addr;

  // Values sampled in the most recent step, for literal checks
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit r, input bit idr, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input bit spur);
    bit exp_valid, exp_req, pop, acc, rsp;
    int occ;
    logic [31:0] pc_before;
    reset          = r;
    id_ready       = idr;
    imem_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (m_acc_prev) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(m_acc_addr);
    end else if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end

    exp_valid = !r && (q_pc.size() > 0);
    pop       = exp_valid && idr;
    occ       = q_pc.size() + (m_infl ? 1 : 0) - (pop ? 1 : 0);
    exp_req   = !r && !redir && (occ < BUF_DEPTH);
    acc       = exp_req && rdy;

    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_fetch_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("if_pc", if_pc, q_pc[0]);
      check("if_instr", if_instr, q_instr[0]);
    end else if (r) begin
      check("if_pc_rst", if_pc, 32'h0);
      check("if_instr_rst", if_instr, 32'h0);
    end

    pc_before = m_fetch_pc;
    if (r) begin
      q_pc.delete(); q_instr.delete();
      m_infl = 0; m_infl_drop = 0;
      m_fetch_pc = RESET_PC;
    end else begin
      rsp = imem_rvalid && m_infl;
      if (redir) begin
        q_pc.delete(); q_instr.delete();
        m_infl_drop = m_infl && !imem_rvalid;
        m_fetch_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (pop) begin void'(q_pc.pop_front()); void'(q_instr.pop_front()); end
        if (rsp && !m_infl_drop) begin q_pc.push_back(m_infl_pc); q_instr.push_back(imem_rdata); end
      end
      if (rsp) begin m_infl = 0; m_infl_drop = 0; end
      if (acc) begin
        m_infl = 1; m_infl_drop = 0; m_infl_pc = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    m_acc_prev = acc;
    m_acc_addr = pc_before;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; id_ready = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0;
    m_fetch_pc = RESET_PC; m_infl = 0; m_infl_drop = 0; m_infl_pc = '0;
    m_acc_prev = 0; m_acc_addr = '0;
    @(posedge clk); #1;

    // Reset state
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    check("rst_req", {31'b0, s_req}, 32'd0);
    check("rst_valid", {31'b0, s_valid}, 32'd0);

    // Streaming fetch: addresses 0,4,8 back to back, if_valid from cycle 2
    step(0, 1, 1, 0, 0, 0);
    check("s31_addr0", s_addr, 32'h0);
    step(0, 1, 1, 0, 0, 0);
    check("s31_addr1", s_addr, 32'h4);
    check("s31_nvalid1", {31'b0, s_valid}, 32'd0);
    step(0, 1, 1, 0, 0, 0);
    check("s31_addr2", s_addr, 32'h8);
    check("s31_valid2", {31'b0, s_valid}, 32'd1);
    check("s31_pc2", s_pc, 32'h0);
    step(0, 1, 1, 0, 0, 0);
    check("s31_pc3", s_pc, 32'h4);
    check("s31_instr3", s_instr, 32'h1);
    step(0, 1, 1, 0, 0, 0);
    check("s31_pc4", s_pc, 32'h8);

    // Consumer stalled: exactly two requests, then resume at 8
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("s32_req1", {31'b0, s_req}, 32'd1);
    step(0, 0, 1, 0, 0, 0);
    check("s32_req2_low", {31'b0, s_req}, 32'd0);
    step(0, 0, 1, 0, 0, 0);
    check("s32_req3_low", {31'b0, s_req}, 32'd0);
    check("s32_pc_hold", s_pc, 32'h0);
    step(0, 1, 1, 0, 0, 0);
    check("s32_resume_req", {31'b0, s_req}, 32'd1);
    check("s32_resume_addr", s_addr, 32'h8);

    // Redirect one cycle after request 0x8 accepted
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check("s33_addr8", s_addr, 32'h8);
    step(0, 1, 1, 1, 32'h0000_0103, 0);
    step(0, 1, 1, 0, 0, 0);
    check("s33_addr", s_addr, 32'h100);
    check("s33_flushed", {31'b0, s_valid}, 32'd0);
    step(0, 1, 1, 0, 0, 0);
    check("s33_no_stale", {31'b0, s_valid}, 32'd0);
    step(0, 1, 1, 0, 0, 0);
    check("s33_pc", s_pc, 32'h100);
    check("s33_valid", {31'b0, s_valid}, 32'd1);

    // Memory stall at 0x10
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      check("s34_req", {31'b0, s_req}, 32'd1);
      check("s34_addr", s_addr, 32'h10);
      check("s34_nopush", {31'b0, s_valid}, 32'd0);
    end
    step(0, 1, 1, 0, 0, 0);

    // Mid-run reset with one buffered and one in flight, then a spurious rvalid
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    check("s35_valid_off", {31'b0, s_valid}, 32'd0);
    check("s35_addr", s_addr, RESET_PC);
    step(0, 1, 1, 0, 0, 0);
    check("s35_spur_ignored", {31'b0, s_valid}, 32'd0);
    step(0, 1, 1, 0, 0, 0);
    check("s35_pc", s_pc, RESET_PC);
    check("s35_instr", s_instr, mem_word(RESET_PC));

    // Address wrap
    step(0, 1, 1, 1, 32'hFFFF_FFFC, 0);
    step(0, 1, 1, 0, 0, 0);
    check("s36_addr_top", s_addr, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0, 0);
    check("s36_addr_wrap", s_addr, 32'h0);
    step(0, 1, 1, 0, 0, 0);
    check("s36_pc_top", s_pc, 32'hFFFF_FFFC);
    check("s36_instr_top", s_instr, 32'h3FFF_FFFF);
    step(0, 1, 1, 0, 0, 0);
    check("s36_pc_wrap", s_pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit r, idr, rdy, redir, spur;
      logic [31:0] rpc;
      r     = ($urandom_range(0, 63) == 0);
      idr   = ($urandom_range(0, 9) < 7);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      spur  = ($urandom_range(0, 7) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r, idr, rdy, redir, rpc, spur);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
